// File: rtl/cordic_pkg.sv
// cordic_pkg: shared definitions for the sequential CORDIC sine/cosine block.
//   state_t    - controller states (IDLE, LOAD, ITER, DONE)
//   SEC_*      - 2-bit quadrant-folding sector codes from range reduction
//   K_INIT     - CORDIC gain compensation, ~0.60725 in Q2.14
//   atan_q88() - arctangent table, atan(2^-i) in Q8.8 degrees
package cordic_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Residual relation to the reduced angle a for each sector.
   localparam logic [1:0] SEC_A    = 2'b00;  // residual = a
   localparam logic [1:0] SEC_A90  = 2'b01;  // residual = a - 90
   localparam logic [1:0] SEC_A270 = 2'b10;  // residual = a - 270
   localparam logic [1:0] SEC_A360 = 2'b11;  // residual = a - 360

   localparam logic signed [15:0] K_INIT = 16'sh26DD;

   function automatic logic signed [15:0] atan_q88(input logic [3:0] i);
      case (i)
         4'd0:    atan_q88 = 16'sd11520;
         4'd1:    atan_q88 = 16'sd6801;
         4'd2:    atan_q88 = 16'sd3593;
         4'd3:    atan_q88 = 16'sd1824;
         4'd4:    atan_q88 = 16'sd916;
         4'd5:    atan_q88 = 16'sd458;
         4'd6:    atan_q88 = 16'sd229;
         4'd7:    atan_q88 = 16'sd115;
         4'd8:    atan_q88 = 16'sd57;
         4'd9:    atan_q88 = 16'sd29;
         4'd10:   atan_q88 = 16'sd14;
         4'd11:   atan_q88 = 16'sd7;
         default: atan_q88 = '0;
      endcase
   endfunction

endpackage

// File: rtl/cordic_range_reduce.sv
// cordic_range_reduce: folds an integer-degree angle into a CORDIC-friendly
// residual in [-90,+90] degrees plus a sector code for output correction.
//   angle    in  16b signed integer degrees, any value
//   residual out 16b signed Q8.8 degrees in [-90,+90]
//   sector   out 2b sector code (SEC_* from cordic_pkg)
module cordic_range_reduce
   import cordic_pkg::*;
(
   input  logic signed [15:0] angle,
   output logic signed [15:0] residual,
   output logic        [1:0]  sector
);

   logic signed [15:0] rem;  // angle rem 360, same sign as angle, |rem| < 360
   logic signed [15:0] deg;  // residual in whole degrees

   always_comb begin
      // Remainder magnitude never exceeds the dividend, so -32768 is safe.
      rem    = angle % 16'sd360;
      sector = SEC_A;
      deg    = rem;
      if (rem >= 16'sd0) begin
         if (rem <= 16'sd90) begin
            sector = SEC_A;
            deg    = rem;
         end else if (rem <= 16'sd180) begin
            sector = SEC_A90;
            deg    = rem - 16'sd90;
         end else if (rem <= 16'sd270) begin
            sector = SEC_A270;
            deg    = rem - 16'sd270;
         end else begin
            sector = SEC_A360;
            deg    = rem - 16'sd360;
         end
      end else begin
         // Negative remainders mirror the positive folding so that -90 and
         // -180 land on residual -90 rather than wrapping through +270.
         if (rem >= -16'sd90) begin
            sector = SEC_A360;
            deg    = rem;
         end else if (rem >= -16'sd180) begin
            sector = SEC_A270;
            deg    = rem + 16'sd90;
         end else if (rem >= -16'sd270) begin
            sector = SEC_A90;
            deg    = rem + 16'sd270;
         end else begin
            sector = SEC_A;
            deg    = rem + 16'sd360;
         end
      end
      residual = deg <<< 8;
   end

endmodule

// File: rtl/cordic_seq.sv
// cordic_seq: iterative (one micro-rotation per cycle) CORDIC sine/cosine.
//   clk, rst   clock and synchronous active-high reset
//   in_valid   in  request present        in_angle  in  16b signed degrees
//   in_ready   out accepting (IDLE only)
//   out_valid  out result held stable     out_ready in  consumer accepts
//   out_cos    out 16b signed Q2.14       out_sin   out 16b signed Q2.14
//   busy       out any state but IDLE
// Parameter ITER (1..12): number of micro-rotations.
module cordic_seq
   import cordic_pkg::*;
#(
   parameter int unsigned ITER = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic signed [15:0] in_angle,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_cos,
   output logic signed [15:0] out_sin,
   output logic               busy
);

   localparam logic [3:0] LAST = 4'(ITER - 1);

   state_t state, state_nx;

   logic signed [15:0] angle_q;
   logic signed [15:0] x, y, z;
   logic        [3:0]  cnt;
   logic        [1:0]  sector_q;

   logic signed [15:0] rr_residual;
   logic        [1:0]  rr_sector;
   logic signed [15:0] x_sh, y_sh, atan_i;

   cordic_range_reduce u_rr (
      .angle    (angle_q),
      .residual (rr_residual),
      .sector   (rr_sector)
   );

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);

   always_comb begin
      x_sh   = x >>> cnt;
      y_sh   = y >>> cnt;
      atan_i = atan_q88(cnt);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (in_valid) state_nx = S_LOAD;
         S_LOAD: state_nx = S_ITER;
         S_ITER: if (cnt == LAST) state_nx = S_DONE;
         S_DONE: if (out_valid && out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         angle_q   <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         cnt       <= '0;
         sector_q  <= '0;
         out_cos   <= '0;
         out_sin   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) angle_q <= in_angle;
            end
            S_LOAD: begin
               x        <= K_INIT;
               y        <= '0;
               z        <= rr_residual;
               cnt      <= '0;
               sector_q <= rr_sector;
            end
            S_ITER: begin
               if (!z[15]) begin
                  x <= x - y_sh;
                  y <= y + x_sh;
                  z <= z - atan_i;
               end else begin
                  x <= x + y_sh;
                  y <= y - x_sh;
                  z <= z + atan_i;
               end
               cnt <= cnt + 4'd1;
            end
            S_DONE: begin
               // The first DONE cycle sees the final x/y; the corrected
               // result and out_valid are registered together on that edge.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  case (sector_q)
                     SEC_A90: begin
                        out_cos <= -y;
                        out_sin <= x;
                     end
                     SEC_A270: begin
                        out_cos <= y;
                        out_sin <= -x;
                     end
                     default: begin
                        out_cos <= x;
                        out_sin <= y;
                     end
                  endcase
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_seq.sv
module tb_cordic_seq;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic signed [15:0] in_angle;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_cos;
   logic signed [15:0] out_sin;
   logic               busy;

   int total = 0;
   int bad   = 0;
   int cyc;

   cordic_seq #(.ITER(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_angle  (in_angle),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cos   (out_cos),
      .out_sin   (out_sin),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input logic signed [15:0] obs, input int exp);
      int d;
      d = int'(obs) - exp;
      total++;
      assert (!$isunknown(obs) && d >= -16 && d <= 16) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d (+/-16)", tag, obs, exp);
      end
   endtask

   // Present a request now; it is taken on the next rising edge.
   task automatic accept(input string tag, input logic signed [15:0] a);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_angle = a;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_angle = 16'sh7FFF;  // later input changes must be ignored
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   // Cycles from the accept edge until out_valid, bounded.
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run(input string tag, input logic signed [15:0] a,
                      input int ec, input int es);
      accept(tag, a);
      wait_valid(cyc);
      chk({tag, "_latency"}, 32'(cyc), 32'd14);
      chk_near({tag, "_cos"}, out_cos, ec);
      chk_near({tag, "_sin"}, out_sin, es);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_angle  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_cos",       32'(out_cos),   32'd0);
      chk("rst_sin",       32'(out_sin),   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // angle 0 with immediate retirement, then held outputs
      run("a0", 16'sd0, 16384, 0);
      @(posedge clk); #1;
      chk("a0_retired_valid", 32'(out_valid), 32'd0);
      chk("a0_retired_ready", 32'(in_ready),  32'd1);
      chk_near("a0_hold_cos", out_cos, 16384);
      chk_near("a0_hold_sin", out_sin, 0);

      run("a45", 16'sd45, 11585, 11585);
      @(posedge clk); #1;
      run("a180", 16'sd180, -16384, 0);
      @(posedge clk); #1;
      run("am90", -16'sd90, 0, -16384);
      @(posedge clk); #1;
      run("am180", -16'sd180, -16384, 0);
      @(posedge clk); #1;
      run("am32768", -16'sd32768, 16225, -2280);
      @(posedge clk); #1;

      // 450 with back-pressure: result must hold for 5 cycles
      out_ready = 1'b0;
      run("a450", 16'sd450, 0, 16384);
      in_valid = 1'b1;  // a pending request must not sneak in
      in_angle = 16'sd10;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("a450_hold_valid", 32'(out_valid), 32'd1);
         chk("a450_hold_ready", 32'(in_ready),  32'd0);
         chk_near("a450_hold_cos", out_cos, 0);
         chk_near("a450_hold_sin", out_sin, 16384);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;  // handshake edge: no same-cycle acceptance
      chk("a450_post_valid", 32'(out_valid), 32'd0);
      chk("a450_post_ready", 32'(in_ready),  32'd1);
      chk("a450_post_busy",  32'(busy),      32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;

      // reset during ITER cycle 6, then new request right after
      accept("abort", 16'sd60);
      repeat (7) @(posedge clk);  // LOAD + 6 ITER cycles
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready",  32'(in_ready),  32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy",      32'(busy),      32'd0);
      chk("abort_cos",       32'(out_cos),   32'd0);
      run("a30", 16'sd30, 14189, 8192);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cordic_seq.md
CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. Ports are listed with clock and reset first.
- clk, input, 1 bit: the single clock. All state is updated on its rising edge.
- rst, input, 1 bit: synchronous, active-high reset.

REQ-002 SHALL expose the following ports:
- in_valid, input, 1 bit: an angle request is present.
- in_angle, input, 16 bits: signed integer degrees, two's complement, any value.
- in_ready, output, 1 bit: the block can accept a request.
- out_valid, output, 1 bit: the result is held stable.
- out_ready, input, 1 bit: the consumer accepts the result.
- out_cos, output, 16 bits: signed Q2.14 cosine.
- out_sin, output, 16 bits: signed Q2.14 sine.
- busy, output, 1 bit: high in any state except IDLE.

REQ-003 SHALL use the following parameter:
- ITER, default 12: number of CORDIC micro-rotations, allowed range 1..12.

Function
REQ-004 SHALL implement a 4-state FSM with these transitions:
- IDLE -> LOAD on in_valid & in_ready.
- LOAD -> ITER after exactly 1 cycle.
- ITER -> DONE when the iteration counter reaches ITER-1.
- DONE -> IDLE on out_valid & out_ready.

REQ-005 SHALL drive in_ready high only in IDLE. There SHALL be no acceptance in the same cycle that DONE is retired.

REQ-006 SHALL register in_angle at acceptance. Any later change on in_angle SHALL be ignored until the next acceptance.

REQ-007 In LOAD, SHALL perform range reduction of the captured angle:
- Reduce mod 360 to a residual in [-90,+90] degrees, as Q8.8, plus a 2-bit sector.
- Sector map: 00 = a; 01 = a-90; 10 = a-270; 11 = a-360.
- Set z = residual, x = 0x26DD (CORDIC gain K, ≈0.60725 in Q2.14), y = 0, counter = 0.

REQ-008 In ITER, each cycle i SHALL perform one micro-rotation:
- d = +1 if z >= 0, else -1.
- x <= x - d*(y>>>i)
- y <= y + d*(x>>>i)
- z <= z - d*ATAN[i]
- Shifts SHALL be arithmetic.
- x and y SHALL be 16 bits; z SHALL be 16-bit Q8.8.

REQ-009 The iteration counter SHALL be 4 bits and increment once per ITER cycle. On the cycle it equals ITER-1, the FSM SHALL go to DONE with no wrap-around.

REQ-010 On entry to DONE, SHALL apply sector correction from the final x and y:
- Sector 00 or 11: cos = x, sin = y.
- Sector 01: cos = -y, sin = x.
- Sector 10: cos = y, sin = -x.

REQ-011 Output timing SHALL be as follows:
- out_valid SHALL rise exactly ITER+2 cycles after the accept edge (14 with the default ITER).
- out_cos and out_sin SHALL stay stable while out_valid=1 and out_ready=0.

REQ-012 out_cos and out_sin SHALL hold their last value after retirement until the next DONE.

REQ-013 Range reduction SHALL map boundary inputs as follows:
- in_angle = 90 and 180 SHALL both use sector 00 or 01 with residual +90.
- Negative inputs SHALL use the mirrored sectors.
- in_angle = -32768 SHALL not overflow.

Reset
REQ-014 rst SHALL force state to IDLE and clear x, y, z, counter, sector, out_cos and out_sin to 0.
- After reset: in_ready=1, out_valid=0, busy=0.

REQ-015 An rst asserted mid-operation (LOAD, ITER or DONE) SHALL abort the computation with no output. The block SHALL accept a new request on the first cycle after rst deasserts.

Structure
REQ-016 The shared package cordic_pkg SHALL hold:
- the state enum;
- the ATAN table, Q8.8 degrees: 11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7;
- the K constant 0x26DD;
- the sector encoding constants.

REQ-017 The combinational range reduction of REQ-007 SHALL be a separate sub-module, cordic_range_reduce, instantiated once. The FSM, counter and rotation datapath SHALL remain in cordic_seq.

Verification
REQ-018 Error tolerance: all numeric checks SHALL allow ±16 LSB on out_cos and out_sin.

REQ-019 The bench SHALL cover these directed scenarios:
- in_angle=0, out_ready=1 -> out_valid on cycle 14; cos=16384, sin=0.
- in_angle=45 -> cos=11585, sin=11585.
- in_angle=180 -> sector 01; cos=-16384, sin=0.
- in_angle=-90 -> sector 11; cos=0, sin=-16384.
- in_angle=450 with out_ready held 0 for 5 cycles -> cos=0, sin=16384, values stable throughout; in_ready=0 until 1 cycle after the handshake.
- rst pulsed at ITER cycle 6, then in_angle=30 -> no out_valid from the aborted run; cos=14189, sin=8192 on cycle 14 after the new accept.
